// File: rtl/uart_rx_top_if.sv
// Serial-receive front-end signal bundle: line, enable and divider in, FIFO status out.
interface uart_rx_top_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    active_i_top_rx;
    logic                    data_i_serial_top_rx;
    logic [2*DATA_WIDTH:0]   baud_div_top_rx;
    logic                    full_o_top_rx;
    logic                    empty_o_top_rx;

    modport master (
        output active_i_top_rx,
        output data_i_serial_top_rx,
        output baud_div_top_rx,
        input  full_o_top_rx,
        input  empty_o_top_rx
    );

    modport slave (
        input  active_i_top_rx,
        input  data_i_serial_top_rx,
        input  baud_div_top_rx,
        output full_o_top_rx,
        output empty_o_top_rx
    );
endinterface

// File: rtl/uart_rx_top.sv
// 8N1 UART receiver with programmable baud divider feeding a write-only capture FIFO.
module fifo_uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] array_reg [0:FIFO_DEPTH-1];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                array_reg[i] <= '0;
            end
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en && (count != (ADDR_WIDTH+1)'(FIFO_DEPTH))) begin
            array_reg[wr_ptr] <= wr_data;
            wr_ptr            <= wr_ptr + 1'b1;
            count             <= count + 1'b1;
        end
    end

    // Flags trail count by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            full  <= (count == (ADDR_WIDTH+1)'(FIFO_DEPTH));
            empty <= (count == '0);
        end
    end
endmodule

module uart_rx_top #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
) (
    input logic          clk_i_top_rx,
    input logic          rstn_i_top_rx,
    uart_rx_top_if.slave bus
);
    localparam int BW    = 2*DATA_WIDTH + 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                state, state_nx;
    logic [BW-1:0]         baud_q, cnt, half;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  line, active;
    logic                  half_end, bit_end, last_bit;
    logic                  start_det, sample_bit, wr_en;

    assign line     = bus.data_i_serial_top_rx;
    assign active   = bus.active_i_top_rx;
    assign half     = baud_q >> 1;
    assign half_end = (cnt == half - BW'(1));
    assign bit_end  = (cnt == baud_q - BW'(1));
    assign last_bit = (idx == IDX_W'(DATA_WIDTH-1));

    always_ff @(posedge clk_i_top_rx) begin
        if (rstn_i_top_rx) state <= IDLE;
        else               state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!active) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:      if (!line) state_nx = START;
                START:     if (half_end) state_nx = line ? IDLE : DATA;
                DATA:      if (bit_end && last_bit) state_nx = STOP;
                STOP:      if (bit_end) state_nx = line ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (line) state_nx = IDLE;
                default:   state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        start_det  = 1'b0;
        sample_bit = 1'b0;
        wr_en      = 1'b0;
        if (active) begin
            case (state)
                IDLE:    start_det  = !line;
                DATA:    sample_bit = bit_end;
                STOP:    wr_en      = bit_end && line;
                default: ;
            endcase
        end
    end

    // Divider is captured at start detection so mid-frame changes wait for the next frame.
    always_ff @(posedge clk_i_top_rx) begin
        if (rstn_i_top_rx) begin
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            baud_q <= '0;
        end else begin
            if (start_det) begin
                cnt    <= '0;
                baud_q <= bus.baud_div_top_rx;
            end else if (state == START) begin
                cnt <= half_end ? '0 : cnt + BW'(1);
            end else if (state == DATA || state == STOP) begin
                cnt <= bit_end ? '0 : cnt + BW'(1);
            end
            if (state == START && half_end) idx <= '0;
            if (sample_bit) begin
                shift[idx] <= line;
                idx        <= idx + IDX_W'(1);
            end
        end
    end

    fifo_uart_rx #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) fifo_uart_rx_inst (
        .clk     (clk_i_top_rx),
        .rst     (rstn_i_top_rx),
        .wr_en   (wr_en),
        .wr_data (shift),
        .full    (bus.full_o_top_rx),
        .empty   (bus.empty_o_top_rx)
    );
endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: frames driven bit by bit, FIFO storage checked against a scoreboard.
module tb_uart_rx_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] exp_mem [0:31];
    int         exp_cnt = 0;

    uart_rx_top_if #(.DATA_WIDTH(8)) bus();

    uart_rx_top #(.DATA_WIDTH(8), .FIFO_DEPTH(32)) dut (
        .clk_i_top_rx  (clk),
        .rstn_i_top_rx (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem(input int k);
        return dut.fifo_uart_rx_inst.array_reg[k];
    endfunction

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
        exp_cnt = 0;
    endtask

    task automatic model_write(input logic [7:0] b);
        if (exp_cnt < 32) begin
            exp_mem[exp_cnt] = b;
            exp_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_mem%0d", tag, i), 32'(mem(i)), 32'(exp_mem[i]));
        check({tag, "_empty"}, 32'(bus.empty_o_top_rx), 32'(exp_cnt == 0));
        check({tag, "_full"}, 32'(bus.full_o_top_rx), 32'(exp_cnt == 32));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        model_reset();
    endtask

    // Called just after a rising edge; every bit lasts bd edges except a shortened start bit.
    task automatic send_frame(input logic [7:0] b, input int bd, input logic stop_v,
                              input int start_len, input int abort_bit, input int rst_bit,
                              input bit probe);
        int half;
        half = bd / 2;
        bus.baud_div_top_rx = 17'(bd);
        bus.data_i_serial_top_rx = 1'b0;
        hold(start_len);
        if (start_len < bd) begin
            bus.data_i_serial_top_rx = 1'b1;
            hold(bd - start_len);
        end
        for (int i = 0; i < 8; i++) begin
            bus.data_i_serial_top_rx = b[i];
            if (i == abort_bit) bus.active_i_top_rx = 1'b0;
            if (i == rst_bit) begin
                rst = 1'b1;
                hold(2);
                rst = 1'b0;
                model_reset();
                hold(bd - 2);
            end else begin
                hold(bd);
            end
        end
        bus.data_i_serial_top_rx = stop_v;
        if (probe) begin
            hold(half);
            check("probe_before_sample", 32'(mem(0)), 32'h00);
            hold(1);
            check("probe_at_sample", 32'(mem(0)), 32'(b));
            check("probe_empty_lags", 32'(bus.empty_o_top_rx), 32'h1);
            hold(1);
            check("probe_empty_clears", 32'(bus.empty_o_top_rx), 32'h0);
            hold(bd - half - 2);
        end else begin
            hold(bd);
        end
        bus.data_i_serial_top_rx = 1'b1;
        bus.active_i_top_rx = 1'b1;
    endtask

    task automatic good(input logic [7:0] b, input int bd);
        send_frame(b, bd, 1'b1, bd, -1, -1, 1'b0);
        model_write(b);
    endtask

    initial begin
        logic [7:0] r;
        bus.active_i_top_rx = 1'b1;
        bus.data_i_serial_top_rx = 1'b1;
        bus.baud_div_top_rx = 17'd868;
        hold(1);
        do_reset();
        hold(50);
        check_all("reset");

        // Single byte at 115200 baud, with write-edge and flag-lag probes.
        send_frame(8'hA5, 868, 1'b1, 868, -1, -1, 1'b1);
        model_write(8'hA5);
        hold(2);
        check_all("single");

        // Back-to-back fill at a short divider.
        for (int i = 1; i < 32; i++) begin
            r = 8'($urandom_range(0, 255));
            good(r, 16);
            if (i == 30) check("full_before_last", 32'(bus.full_o_top_rx), 32'h0);
        end
        hold(2);
        check_all("fill");

        good(8'h3C, 16);
        hold(2);
        check_all("overflow");

        // Error frames interleaved with good ones.
        do_reset();
        good(8'h11, 16);
        bus.baud_div_top_rx = 17'd256;
        bus.data_i_serial_top_rx = 1'b0;
        hold(100);
        bus.data_i_serial_top_rx = 1'b1;
        hold(300);
        check_all("false_start");
        good(8'h81, 256);
        hold(2);
        check_all("after_false_start");

        send_frame(8'h55, 16, 1'b0, 16, -1, -1, 1'b0);
        hold(20);
        check_all("framing");
        good(8'h82, 16);
        hold(2);
        check_all("after_framing");

        send_frame(8'h00, 16, 1'b1, 16, 3, -1, 1'b0);
        hold(20);
        check_all("abort");
        good(8'h83, 16);
        hold(2);
        check_all("after_abort");

        send_frame(8'h84, 16, 1'b1, 9, -1, -1, 1'b0);
        model_write(8'h84);
        hold(2);
        check_all("short_start");

        good(8'h96, 5);
        good(8'h69, 5);
        hold(2);
        check_all("odd_div");

        send_frame(8'hF0, 16, 1'b1, 16, -1, 5, 1'b0);
        hold(20);
        check_all("midframe_reset");
        good(8'h12, 16);
        hold(2);
        check_all("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
